// File: rtl/bayer_quad_gray_pkg.sv
// Shared geometry, sum widths and line-buffer entry type for bayer_quad_gray.
package bayer_quad_gray_pkg;

  localparam int DEF_ROW_SIZE   = 1280;
  localparam int DEF_PIXEL_SIZE = 12;
  localparam int DEF_COORD_W    = 16;

  localparam int GRAY_COLS   = DEF_ROW_SIZE / 2;
  localparam int LB_ADDR_W   = $clog2(GRAY_COLS);
  localparam int SUM1_W      = DEF_PIXEL_SIZE + 1;
  localparam int SUM2_W      = DEF_PIXEL_SIZE + 2;
  localparam int STATS_CNT_W = 20;

  typedef logic [SUM1_W-1:0] lb_entry_t;

  // Address width for a RAM of 'cols' entries, never below one bit.
  function automatic int addr_w(input int cols);
    return (cols > 1) ? $clog2(cols) : 1;
  endfunction

endpackage

// File: rtl/bayer_quad_gray_line_buffer.sv
// gray_line_buffer: simple dual-port RAM holding even-row pair sums, registered read.
module gray_line_buffer
  import bayer_quad_gray_pkg::*;
#(
  parameter int DEPTH  = GRAY_COLS,
  parameter int ADDR_W = LB_ADDR_W,
  parameter int WIDTH  = $bits(lb_entry_t)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0]  rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_q;

  // No reset on the array or read register so the tools can map it to block RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (re_i) begin
      rd_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/bayer_quad_gray.sv
// Averages each 2x2 Bayer quad into one grey pixel at half resolution.
// Optional frame statistics ports are enabled by defining BAYER_QUAD_GRAY_STATS_EN.
module bayer_quad_gray
  import bayer_quad_gray_pkg::*;
#(
  parameter int ROW_SIZE   = DEF_ROW_SIZE,
  parameter int PIXEL_SIZE = DEF_PIXEL_SIZE,
  parameter int COORD_W    = DEF_COORD_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PIXEL_SIZE-1:0] input_pixel,
  input  logic [COORD_W-1:0]    x_cont,
  input  logic [COORD_W-1:0]    y_cont,
  input  logic                  valid_in,
  output logic [PIXEL_SIZE-1:0] output_pixel,
  output logic [COORD_W-1:0]    out_x,
  output logic [COORD_W-1:0]    out_y,
  output logic                  valid_out
`ifdef BAYER_QUAD_GRAY_STATS_EN
  ,
  output logic                   frame_done,
  output logic [STATS_CNT_W-1:0] frame_pix_cnt
`endif
);

  localparam int GCOLS = ROW_SIZE / 2;
  localparam int AW    = addr_w(GCOLS);
  localparam int S1    = PIXEL_SIZE + 1;
  localparam int S2    = PIXEL_SIZE + 2;
  localparam logic [COORD_W-1:0] ROW_LIM = COORD_W'(ROW_SIZE);

  logic [PIXEL_SIZE-1:0] hold_q, hold_d;
  logic [COORD_W-1:0]    tag_q, tag_d;
  logic                  tag_valid_q, tag_valid_d;
  logic [PIXEL_SIZE-1:0] pix_q, pix_d;
  logic [COORD_W-1:0]    ox_q, ox_d, oy_q, oy_d;
  logic                  vout_q, vout_d;

  logic                  accept, frame_start, tag_match;
  logic [COORD_W-1:0]    x_half, y_half;
  logic [AW-1:0]         lb_addr;
  logic                  lb_we, lb_re;
  logic [S1-1:0]         wr_data, rd_data;
  logic [S2-1:0]         sum;
  logic [PIXEL_SIZE-1:0] avg;

  assign accept      = valid_in && (x_cont < ROW_LIM);
  assign frame_start = accept && (x_cont == '0) && (y_cont == '0);
  assign x_half      = x_cont >> 1;
  assign y_half      = y_cont >> 1;
  assign lb_addr     = x_half[AW-1:0];
  assign wr_data     = S1'(hold_q) + S1'(input_pixel);
  assign sum         = S2'(rd_data) + S2'(hold_q) + S2'(input_pixel);
  assign avg         = PIXEL_SIZE'(sum >> 2);
  // Only pair with the even row directly above; anything else is missing or stale.
  assign tag_match   = tag_valid_q && (tag_q == (y_cont - COORD_W'(1)));

  always_comb begin
    hold_d      = hold_q;
    tag_d       = tag_q;
    tag_valid_d = tag_valid_q;
    pix_d       = pix_q;
    ox_d        = ox_q;
    oy_d        = oy_q;
    vout_d      = 1'b0;
    lb_we       = 1'b0;
    lb_re       = 1'b0;
    if (accept) begin
      if (!y_cont[0]) begin
        if (!x_cont[0]) begin
          hold_d = input_pixel;
          if (frame_start) begin
            tag_valid_d = 1'b0;
          end
        end else begin
          lb_we       = 1'b1;
          tag_d       = y_cont;
          tag_valid_d = 1'b1;
        end
      end else begin
        if (!x_cont[0]) begin
          hold_d = input_pixel;
          lb_re  = 1'b1;
        end else if (tag_match) begin
          pix_d  = avg;
          ox_d   = x_half;
          oy_d   = y_half;
          vout_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q      <= '0;
      tag_q       <= '1;
      tag_valid_q <= 1'b0;
      pix_q       <= '0;
      ox_q        <= '0;
      oy_q        <= '0;
      vout_q      <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      tag_q       <= tag_d;
      tag_valid_q <= tag_valid_d;
      pix_q       <= pix_d;
      ox_q        <= ox_d;
      oy_q        <= oy_d;
      vout_q      <= vout_d;
    end
  end

  gray_line_buffer #(
    .DEPTH (GCOLS),
    .ADDR_W(AW),
    .WIDTH (S1)
  ) u_line_buffer (
    .clk      (clk),
    .we_i     (lb_we),
    .wr_addr_i(lb_addr),
    .wr_data_i(wr_data),
    .re_i     (lb_re),
    .rd_addr_i(lb_addr),
    .rd_data_o(rd_data)
  );

  assign output_pixel = pix_q;
  assign out_x        = ox_q;
  assign out_y        = oy_q;
  assign valid_out    = vout_q;

`ifdef BAYER_QUAD_GRAY_STATS_EN
  logic                   done_q;
  logic [STATS_CNT_W-1:0] cnt_q, cnt_inc, latched_q;

  // The pulse present on the frame-start cycle belongs to the frame just ending.
  assign cnt_inc = (vout_q && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q    <= 1'b0;
      cnt_q     <= '0;
      latched_q <= '0;
    end else begin
      done_q <= frame_start;
      if (frame_start) begin
        latched_q <= cnt_inc;
        cnt_q     <= '0;
      end else begin
        cnt_q <= cnt_inc;
      end
    end
  end

  assign frame_done    = done_q;
  assign frame_pix_cnt = latched_q;
`endif

endmodule

// File: doc/bayer_quad_gray.md
Name: bayer_quad_gray

Overview:
- Sits directly upstream of convolution_top, on the D5M pixel clock.
- Consumes raw 12-bit Bayer pixels, with x/y counts, from the capture stage.
- Averages each 2x2 Bayer quad (R, G1, G2, B) into one 12-bit grey pixel. A 1280x960 sensor window becomes a 640x480 grey stream with its own coordinates.
- A one-row line buffer holds partial quad sums from even rows until the matching odd row arrives.

Parameters:
- ROW_SIZE, 1280: raw pixels per sensor row. Must be even.
- PIXEL_SIZE, 12: raw and grey pixel width in bits.
- COORD_W, 16: width of all x/y coordinate ports.

Ports:
- clk  in  1  pixel clock (D5M_PIXLCLK domain).
- rst_n  in  1  asynchronous, active-low reset.
- input_pixel  in  PIXEL_SIZE  raw Bayer sample.
- x_cont  in  COORD_W  raw column of input_pixel.
- y_cont  in  COORD_W  raw row of input_pixel.
- valid_in  in  1  input_pixel, x_cont and y_cont are valid this cycle.
- output_pixel  out  PIXEL_SIZE  grey quad average.
- out_x  out  COORD_W  grey column = x_cont>>1 of the completing pixel.
- out_y  out  COORD_W  grey row = y_cont>>1.
- valid_out  out  1  single-cycle qualifier for output_pixel, out_x and out_y.

Behaviour:
- Reset: asynchronous and active-low. All outputs go to 0. hold_reg=0, even_row_tag=all-ones, tag_valid=0. Line-buffer contents are don't-care.
- Samples with valid_in=0, or with x_cont>=ROW_SIZE, are ignored entirely: no writes, no state change.
- Parity comes only from x_cont[0] and y_cont[0]. There are no internal pixel counters, so gaps in valid_in are tolerated.
- Even row (y_cont[0]=0):
  - even x: hold_reg <= input_pixel.
  - odd x: linebuf[x_cont>>1] <= hold_reg + input_pixel (PIXEL_SIZE+1 bits). even_row_tag <= y_cont. tag_valid <= 1.
- Odd row (y_cont[0]=1):
  - even x: hold_reg <= input_pixel. Issue a synchronous read of linebuf[x_cont>>1].
  - odd x: sum = rd_data + hold_reg + input_pixel (PIXEL_SIZE+2 bits). Output is registered next cycle.
- Pairing rule: the read for a pair is issued on its even-x sample. Data is available on the following valid odd-x sample, even if valid_in gaps occur. rd_data is held until then.
- Output conditions, registered:
  - On an odd-row, odd-x sample, emit only when tag_valid=1 and even_row_tag == y_cont-1.
  - Otherwise suppress; this covers a missing or stale even row.
- Output values:
  - output_pixel = sum[PIXEL_SIZE+1:2], i.e. truncating divide by 4; the maximum 4*4095 gives 4095, so no overflow.
  - valid_out = 1 for exactly one cycle.
- Latency: valid_out asserts 1 clk after the odd-x, odd-y sample is accepted. Throughput is at most one output per 2 accepted odd-row samples.
- Consecutive odd-x samples without an intervening even-x sample: the second uses the stale hold_reg. This is legal and not flagged.
- Frame start (valid sample with x_cont=0 and y_cont=0): tag_valid <= 0 before the normal even-row processing of that sample.
- Reset mid-frame: output is suppressed until a complete even row followed by its odd row is seen.
- y_cont wrap from max to 0: handled by the frame-start rule.
- Simultaneous line-buffer read and write in the same cycle cannot occur, because rows have a single parity.

Optional Feature:
- Macro: BAYER_QUAD_GRAY_STATS_EN.
- Defined: adds two output ports.
  - frame_done (1 bit): one-cycle pulse, 1 clk after the frame-start sample.
  - frame_pix_cnt (20 bits): number of valid_out pulses in the completed frame. Latched on frame_done; the internal counter then clears. Both reset to 0.
  - The counter saturates at 2^20-1.
- Undefined: neither port nor counter exists. Core behaviour is identical.

Decomposition:
- Package bayer_quad_gray_pkg holds:
  - GRAY_COLS = ROW_SIZE/2 and LB_ADDR_W = $clog2(GRAY_COLS).
  - Sum widths PIXEL_SIZE+1 and PIXEL_SIZE+2.
  - A typedef for the line-buffer entry.
- One sub-module, gray_line_buffer: simple dual-port RAM, GRAY_COLS x (PIXEL_SIZE+1), synchronous write, registered read. It must infer M10K.

Test Plan:
- Flat frame: 4x2 raw window of all 100, ROW_SIZE=4 → two outputs of 100 at (0,0) and (1,0), each 1 clk after x=1 and x=3 of row 1.
- Quad arithmetic: R=4095, G1=4095, G2=4095, B=4095 → 4095. R=1, G1=2, G2=3, B=5 → 2 (11/4 truncated).
- Gapped input: insert 3 idle cycles between every valid sample of rows 0 and 1 → identical values and coordinates as the gap-free run.
- Missing even row: start stimulus at y_cont=1 after reset, then rows 2 and 3 → no valid_out on row 1; row-3 outputs correct at out_y=1.
- Async reset mid-row-1: assert rst_n=0 → outputs 0 immediately. After release, no output until the next even/odd pair completes.
- STATS_EN: a full 1280x960 frame followed by the next frame start → frame_done pulses once, frame_pix_cnt=307200.
